iob_tdp_mem_arb: RTL and testbench

Round-robin arbiter and initialiser for one port of the byte-write-enable true-dual-port RAM. It shares a single RAM port among N_REQ native-bus requesters, grants at most one access per cycle and routes the registered read data back to the owner. After reset, or on request, it zero-fills the whole RAM before granting any access. It sits between the RAM port and the requesters (CPU data, DMA), all in one clock domain.

---
 rtl/iob_tdp_mem_arb_pkg.sv | 25 ++
 rtl/iob_tdp_mem_arb_if.sv | 35 +++
 rtl/iob_tdp_mem_arb_rr_arb.sv | 33 +++
 rtl/iob_tdp_mem_arb.sv | 125 ++++++++++++
 tb/tb_iob_tdp_mem_arb.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iob_tdp_mem_arb_pkg.sv
// Shared types and width helpers for the TDP RAM port arbiter/initialiser.
package iob_tdp_mem_arb_pkg;

  // FILL zero-fills the RAM, RUN arbitrates requester accesses
  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_N_REQ      = 2;
  localparam int DEF_NUM_COL    = 4;
  localparam int DEF_COL_WIDTH  = 8;
  localparam int DEF_ADDR_WIDTH = 10;

  // Width of a requester index / round-robin pointer (at least one bit)
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // The fill counter walks every word address, so it is as wide as the address
  function automatic int cnt_width(input int addr_width);
    return addr_width;
  endfunction

endpackage

// File: rtl/iob_tdp_mem_arb_if.sv
// Requester-side native bus plus RAM-port bus for the arbiter.
// slave: the arbiter's view. master: the requesters/RAM environment's view.
interface iob_tdp_mem_arb_if #(
  parameter int N_REQ      = 2,
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH
);

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [N_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [N_REQ*NUM_COL-1:0]    req_wstrb;
  logic [N_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]       req_rdata;
  logic [N_REQ-1:0]            req_rvalid;

  logic                        mem_en;
  logic [NUM_COL-1:0]          mem_we;
  logic [ADDR_WIDTH-1:0]       mem_addr;
  logic [DATA_WIDTH-1:0]       mem_din;
  logic [DATA_WIDTH-1:0]       mem_dout;

  modport slave (
    input  req_valid, req_addr, req_wdata, req_wstrb, mem_dout,
    output req_ready, req_rdata, req_rvalid, mem_en, mem_we, mem_addr, mem_din
  );

  modport master (
    output req_valid, req_addr, req_wdata, req_wstrb, mem_dout,
    input  req_ready, req_rdata, req_rvalid, mem_en, mem_we, mem_addr, mem_din
  );

endinterface

// File: rtl/iob_tdp_mem_arb_rr_arb.sv
// Combinational round-robin grant: first valid requester at or after ptr.
module iob_rr_arb
  import iob_tdp_mem_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  localparam int PTR_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] grant_idx
);

  int   idx;
  logic found;

  // Search ptr, ptr+1, ... modulo N_REQ and stop at the first valid requester
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/iob_tdp_mem_arb.sv
// Arbiter and zero-fill initialiser for one port of the byte-write TDP RAM.
module iob_tdp_mem_arb
  import iob_tdp_mem_arb_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int NUM_COL    = DEF_NUM_COL,
  parameter int COL_WIDTH  = DEF_COL_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_start,
  output logic             init_done,
  iob_tdp_mem_arb_if.slave bus
);

  localparam int PTR_W = idx_width(N_REQ);
  localparam int CNT_W = cnt_width(ADDR_WIDTH);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [N_REQ-1:0]      rvalid_q, rvalid_d;

  logic [N_REQ-1:0]      arb_valid;
  logic [N_REQ-1:0]      grant;
  logic [PTR_W-1:0]      grant_idx;
  logic                  grant_any;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [NUM_COL-1:0]    sel_wstrb;

  // Requests are only visible to the arbiter once the fill has finished
  assign arb_valid = bus.req_valid & {N_REQ{state_q == RUN}};
  assign grant_any = |grant;

  iob_rr_arb #(
    .N_REQ(N_REQ)
  ) u_rr_arb (
    .valid    (arb_valid),
    .ptr      (ptr_q),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  // Pick out the granted requester's address, data and strobes
  always_comb begin
    sel_addr  = bus.req_addr[int'(grant_idx) * ADDR_WIDTH +: ADDR_WIDTH];
    sel_wdata = bus.req_wdata[int'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
    sel_wstrb = bus.req_wstrb[int'(grant_idx) * NUM_COL +: NUM_COL];
  end

  // Drive the RAM port; held quiet while rst is high so fill writes begin only after release
  always_comb begin
    bus.mem_en   = 1'b0;
    bus.mem_we   = '0;
    bus.mem_addr = '0;
    bus.mem_din  = '0;
    if (!rst) begin
      if (state_q == FILL) begin
        bus.mem_en   = 1'b1;
        bus.mem_we   = '1;
        bus.mem_addr = ADDR_WIDTH'(cnt_q);
      end else if (grant_any) begin
        bus.mem_en   = 1'b1;
        bus.mem_we   = sel_wstrb;
        bus.mem_addr = sel_addr;
        bus.mem_din  = sel_wdata;
      end
    end
  end

  // Requester-facing outputs: combinational ready, registered read strobe, RAM data passthrough
  always_comb begin
    bus.req_ready  = grant;
    bus.req_rvalid = rvalid_q;
    bus.req_rdata  = bus.mem_dout;
    init_done      = (state_q == RUN);
  end

  // Next state: fill counter walk, clear handling, pointer advance and read-response tag
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    rvalid_d = '0;
    unique case (state_q)
      FILL: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (clear_start) begin
          state_d = FILL;
          cnt_d   = '0;
        end
      end
    endcase
    if (grant_any) begin
      ptr_d = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      if (sel_wstrb == '0) begin
        rvalid_d = grant;
      end
    end
  end

  // FSM state, fill counter, round-robin pointer and read-response flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FILL;
      cnt_q    <= '0;
      ptr_q    <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
    end
  end

endmodule

// File: tb/tb_iob_tdp_mem_arb.sv
// Self-checking bench for iob_tdp_mem_arb with a 16-word RAM model and a read scoreboard.
module tb_iob_tdp_mem_arb;

  localparam int N_REQ      = 2;
  localparam int NUM_COL    = 4;
  localparam int COL_WIDTH  = 8;
  localparam int ADDR_WIDTH = 4;
  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear_start = 1'b0;
  logic init_done;

  iob_tdp_mem_arb_if #(
    .N_REQ(N_REQ), .NUM_COL(NUM_COL), .COL_WIDTH(COL_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
  ) bus ();

  iob_tdp_mem_arb #(
    .N_REQ(N_REQ), .NUM_COL(NUM_COL), .COL_WIDTH(COL_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear_start(clear_start),
    .init_done  (init_done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;

  typedef struct {
    int          idx;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [1:0]  mon_rv;
  logic [31:0] exp_mem [DEPTH];
  int          exp_ptr;
  logic [31:0] ram [DEPTH];

  // Cycle counter used to check response latency
  always @(posedge clk) cycle <= cycle + 1;

  // Read-first byte-write RAM; contents scrambled while rst is held
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) ram[k] <= 32'hA5A5A5A5;
    end else if (bus.mem_en) begin
      bus.mem_dout <= ram[bus.mem_addr];
      for (int c = 0; c < NUM_COL; c++)
        if (bus.mem_we[c]) ram[bus.mem_addr][c*8 +: 8] <= bus.mem_din[c*8 +: 8];
    end
  end

  // Scoreboard: every read response is matched against the oldest expected read
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.req_rvalid != '0) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL read_resp unexpected: rvalid=%b rdata=%h, required no response", bus.req_rvalid, bus.req_rdata);
        end else begin
          mon_e  = sb.pop_front();
          mon_rv = 2'b01 << mon_e.idx;
          if (bus.req_rvalid !== mon_rv || bus.req_rdata !== mon_e.data || cycle != mon_e.due) begin
            miscompares++;
            $display("[TB] FAIL read_resp: rvalid=%b rdata=%h cycle=%0d, required rvalid=%b rdata=%h cycle=%0d",
                     bus.req_rvalid, bus.req_rdata, cycle, mon_rv, mon_e.data, mon_e.due);
          end
        end
      end else if (sb.size() > 0 && sb[0].due <= cycle) begin
        vectors++;
        miscompares++;
        mon_e = sb.pop_front();
        $display("[TB] FAIL read_resp missing: rvalid=%b at cycle %0d, required req%0d data %h", bus.req_rvalid, cycle, mon_e.idx, mon_e.data);
      end
    end
  end

  task automatic set_req(input int i, input logic v, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.req_valid[i] = v;
    bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = a;
    bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH] = d;
    bus.req_wstrb[i*NUM_COL +: NUM_COL] = s;
  endtask

  task automatic clear_model();
    for (int k = 0; k < DEPTH; k++) exp_mem[k] = 32'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One single-requester access starting just after a rising edge; reads go to the scoreboard
  task automatic do_access(input int i, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    set_req(i, 1'b1, a, d, s);
    @(negedge clk);
    if (s == 4'b0) begin
      sb.push_back('{idx: i, data: exp_mem[a], due: cycle + 1});
    end else begin
      for (int c = 0; c < NUM_COL; c++)
        if (s[c]) exp_mem[a][c*8 +: 8] = d[c*8 +: 8];
    end
    exp_ptr = (i + 1) % N_REQ;
    @(posedge clk);
    #1;
    set_req(i, 1'b0, 4'h0, 32'h0, 4'h0);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({init_done, bus.req_ready, bus.req_rvalid, bus.mem_en, bus.mem_we} !== 10'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: init_done=%b ready=%b rvalid=%b en=%b we=%h, required all zero",
               init_done, bus.req_ready, bus.req_rvalid, bus.mem_en, bus.mem_we);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    exp_ptr = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.mem_en !== 1'b1 || bus.mem_we !== 4'hF || bus.mem_addr !== ADDR_WIDTH'(i) ||
          bus.mem_din !== 32'h0 || init_done !== 1'b0 || bus.req_ready !== 2'b00) begin
        miscompares++;
        $display("[TB] FAIL fill_cycle %0d: en=%b we=%h addr=%0d din=%h init_done=%b, required en=1 we=f addr=%0d din=0 init_done=0",
                 i, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_din, init_done, i);
      end
    end
    @(negedge clk);
    vectors++;
    if (init_done !== 1'b1 || bus.mem_en !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL init_done_rise: init_done=%b en=%b, required init_done=1 en=0", init_done, bus.mem_en);
    end
    @(posedge clk);
    #1;
    do_access(0, 4'd5, 32'h0, 4'h0);
    idle(2);
  endtask

  task automatic test_partial_write();
    do_access(0, 4'd3, 32'hDEADBEEF, 4'b0101);
    do_access(0, 4'd3, 32'h0, 4'h0);
    idle(2);
  endtask

  task automatic test_alternate();
    int g;
    logic [3:0] ga;
    do_access(1, 4'd4, 32'hCAFE0123, 4'hF);
    set_req(0, 1'b1, 4'd3, 32'h0, 4'h0);
    set_req(1, 1'b1, 4'd4, 32'h0, 4'h0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      g  = exp_ptr;
      ga = (g == 0) ? 4'd3 : 4'd4;
      vectors++;
      if (bus.req_ready !== (2'b01 << g) || bus.mem_addr !== ga || bus.mem_we !== 4'h0) begin
        miscompares++;
        $display("[TB] FAIL alternate_grant %0d: ready=%b addr=%0d we=%h, required ready=%b addr=%0d we=0",
                 k, bus.req_ready, bus.mem_addr, bus.mem_we, 2'b01 << g, ga);
      end
      sb.push_back('{idx: g, data: exp_mem[ga], due: cycle + 1});
      exp_ptr = (g + 1) % N_REQ;
      @(posedge clk);
      #1;
    end
    set_req(0, 1'b0, 4'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 4'h0, 32'h0, 4'h0);
    idle(2);
  endtask

  task automatic test_requests_during_fill();
    rst = 1'b1;
    set_req(0, 1'b1, 4'd1, 32'h0, 4'h0);
    set_req(1, 1'b1, 4'd2, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    exp_ptr = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.req_ready !== 2'b00 || init_done !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL ready_in_fill %0d: ready=%b init_done=%b, required ready=00 init_done=0", i, bus.req_ready, init_done);
      end
    end
    @(negedge clk);
    vectors++;
    if (init_done !== 1'b1 || bus.req_ready !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL first_grant: init_done=%b ready=%b, required init_done=1 ready=01", init_done, bus.req_ready);
    end
    sb.push_back('{idx: 0, data: exp_mem[1], due: cycle + 1});
    @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL second_grant: ready=%b, required ready=10", bus.req_ready);
    end
    sb.push_back('{idx: 1, data: exp_mem[2], due: cycle + 1});
    exp_ptr = 0;
    @(posedge clk);
    #1;
    set_req(0, 1'b0, 4'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 4'h0, 32'h0, 4'h0);
    idle(2);
  endtask

  task automatic test_clear();
    do_access(0, 4'd7, 32'h12345678, 4'hF);
    do_access(1, 4'd7, 32'h0, 4'h0);
    idle(2);
    set_req(0, 1'b1, 4'd7, 32'h0, 4'h0);
    clear_start = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL clear_same_cycle_grant: ready=%b, required ready=01", bus.req_ready);
    end
    sb.push_back('{idx: 0, data: exp_mem[7], due: cycle + 1});
    exp_ptr = 1;
    @(posedge clk);
    #1;
    clear_start = 1'b0;
    set_req(0, 1'b0, 4'h0, 32'h0, 4'h0);
    clear_model();
    @(negedge clk);
    vectors++;
    if (init_done !== 1'b0 || bus.mem_addr !== 4'd0 || bus.mem_we !== 4'hF) begin
      miscompares++;
      $display("[TB] FAIL clear_refill_start: init_done=%b addr=%0d we=%h, required init_done=0 addr=0 we=f", init_done, bus.mem_addr, bus.mem_we);
    end
    for (int i = 1; i < DEPTH; i++) begin
      @(posedge clk);
      #1;
      clear_start = (i == 3);
      @(negedge clk);
      vectors++;
      if (bus.mem_en !== 1'b1 || bus.mem_addr !== ADDR_WIDTH'(i) || bus.mem_din !== 32'h0) begin
        miscompares++;
        $display("[TB] FAIL refill_cycle %0d: en=%b addr=%0d din=%h, required en=1 addr=%0d din=0", i, bus.mem_en, bus.mem_addr, bus.mem_din, i);
      end
    end
    @(posedge clk);
    #1;
    clear_start = 1'b0;
    @(negedge clk);
    vectors++;
    if (init_done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL refill_done: init_done=%b, required 1", init_done);
    end
    @(posedge clk);
    #1;
    do_access(1, 4'd7, 32'h0, 4'h0);
    idle(2);
  endtask

  task automatic test_reset_mid_fill();
    logic found;
    clear_start = 1'b1;
    @(posedge clk);
    #1;
    clear_start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.mem_en === 1'b1 && bus.mem_addr === 4'd6) begin
        found = 1'b1;
        break;
      end
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("[TB] FAIL reach_fill_addr6: addr=%0d, required fill to reach address 6 within 40 cycles", bus.mem_addr);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({init_done, bus.req_ready, bus.req_rvalid, bus.mem_en, bus.mem_we} !== 10'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_fill: init_done=%b ready=%b rvalid=%b en=%b we=%h, required all zero",
               init_done, bus.req_ready, bus.req_rvalid, bus.mem_en, bus.mem_we);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    exp_ptr = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.mem_en !== 1'b1 || bus.mem_addr !== ADDR_WIDTH'(i) || bus.mem_we !== 4'hF) begin
        miscompares++;
        $display("[TB] FAIL restart_fill %0d: en=%b addr=%0d we=%h, required en=1 addr=%0d we=f", i, bus.mem_en, bus.mem_addr, bus.mem_we, i);
      end
    end
    @(posedge clk);
    #1;
    do_access(0, 4'd6, 32'h0, 4'h0);
    idle(3);
  endtask

  // Abort guard in case the run never reaches its summary
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
    clear_model();
    exp_ptr = 0;
    test_reset();
    test_partial_write();
    test_alternate();
    test_requests_during_fill();
    test_clear();
    test_reset_mid_fill();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: pending=%0d, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
